// File: rtl/apb_master_bridge.sv
// APB3 requester: turns valid/ready commands into SETUP/ACCESS transfers. Optional watchdog: APB_MASTER_TIMEOUT_EN.
// Latency: accept to rsp_valid is 4 cycles against a slave that registers pready; one transfer per 4 cycles peak.
// Backpressure: cmd_ready is low whenever a transfer is in flight; rsp_valid cannot be stalled.
module apb_master_bridge #(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic              pslverr,
    input  logic [DATA_W-1:0] prdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic                psel_nxt;
    logic                penable_nxt;
    logic                pwrite_nxt;
    logic [ADDR_W-1:0]   paddr_nxt;
    logic [DATA_W-1:0]   pwdata_nxt;
    logic                rsp_valid_nxt;
    logic [DATA_W-1:0]   rsp_rdata_nxt;
    logic                rsp_err_nxt;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
        $error("apb_master_bridge: TIMEOUT must be within 2..255");
    end

`ifdef APB_MASTER_TIMEOUT_EN
    logic [7:0] wait_cnt, wait_cnt_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= 8'd0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
        end
    end
`endif

    assign cmd_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            psel      <= psel_nxt;
            penable   <= penable_nxt;
            pwrite    <= pwrite_nxt;
            paddr     <= paddr_nxt;
            pwdata    <= pwdata_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
        end
    end

    // pready/pslverr only matter in ACCESS, so a stale pready seen during SETUP is ignored.
    always_comb begin
        state_nxt     = state;
        psel_nxt      = psel;
        penable_nxt   = penable;
        pwrite_nxt    = pwrite;
        paddr_nxt     = paddr;
        pwdata_nxt    = pwdata;
        rsp_valid_nxt = 1'b0;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_nxt  = wait_cnt;
`endif
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nxt   = SETUP;
                    psel_nxt    = 1'b1;
                    penable_nxt = 1'b0;
                    pwrite_nxt  = cmd_write;
                    paddr_nxt   = cmd_addr;
                    pwdata_nxt  = cmd_wdata;
                end
            end
            SETUP: begin
                state_nxt   = ACCESS;
                penable_nxt = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
                wait_cnt_nxt = 8'd0;
`endif
            end
            ACCESS: begin
                if (pready) begin
                    state_nxt     = IDLE;
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = pslverr;
                    rsp_rdata_nxt = pwrite ? '0 : prdata;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                // This edge would be the TIMEOUT-th stalled ACCESS cycle: give up.
                else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                    state_nxt     = IDLE;
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b1;
                    rsp_rdata_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
`endif
            end
            default: begin
                state_nxt   = IDLE;
                psel_nxt    = 1'b0;
                penable_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomised bench for apb_master_bridge: behavioural APB slave, timeline-based reference model, per-cycle compare.
module tb_apb_master_bridge;
    localparam int TMO = 4;

    logic        clk, rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [2:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite;
    logic [2:0]  paddr;
    logic [31:0] pwdata;
    logic        pready, pslverr;
    logic [31:0] prdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Per-command slave behaviour: number of stalled ACCESS cycles and error injection.
    int cmd_waits;
    bit cmd_err;
    int swq[$];
    bit seq[$];

    // Observed responses (cycle stamp, data, err) for directed checks.
    int          rq_cyc[$];
    logic [31:0] rq_dat[$];
    logic        rq_err[$];

    // Reference model state.
    bit          have;
    int          t_start, t_done;
    bit          busy, exp_rv, abort;
    logic [2:0]  m_paddr;
    logic        m_pwrite;
    logic [31:0] m_pwdata, m_rdata, t_rdata;
    logic        m_err, t_err;
    logic [31:0] ref_mem [8];

    // Slave environment state.
    logic [31:0] slv_mem [8];
    int          wl;
    bit          er;

    apb_master_bridge #(.ADDR_W(3), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready), .pslverr(pslverr), .prdata(prdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Reference model and per-cycle compare, sampled mid-cycle.
    initial begin
        have = 0; t_start = 0; t_done = 0;
        m_paddr = 0; m_pwrite = 0; m_pwdata = 0; m_rdata = 0; m_err = 0;
        t_rdata = 0; t_err = 0;
        foreach (ref_mem[i]) ref_mem[i] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                have = 0;
                m_paddr = 0; m_pwrite = 0; m_pwdata = 0; m_rdata = 0; m_err = 0;
                foreach (ref_mem[i]) ref_mem[i] = 0;
                chk("reset_cmd_ready", cmd_ready, 1);
                chk("reset_psel", psel, 0);
                chk("reset_penable", penable, 0);
                chk("reset_pwrite", pwrite, 0);
                chk("reset_paddr", paddr, 0);
                chk("reset_pwdata", pwdata, 0);
                chk("reset_rsp_valid", rsp_valid, 0);
                chk("reset_rsp_rdata", rsp_rdata, 0);
                chk("reset_rsp_err", rsp_err, 0);
            end else begin
                busy   = have && (cyc >= t_start) && (cyc < t_done);
                exp_rv = have && (cyc == t_done);
                if (exp_rv) begin
                    m_rdata = t_rdata;
                    m_err   = t_err;
                end
                chk("cmd_ready", cmd_ready, !busy);
                chk("psel", psel, busy);
                chk("penable", penable, busy && (cyc > t_start));
                chk("pwrite", pwrite, m_pwrite);
                chk("paddr", paddr, m_paddr);
                chk("pwdata", pwdata, m_pwdata);
                chk("rsp_valid", rsp_valid, exp_rv);
                chk("rsp_rdata", rsp_rdata, m_rdata);
                chk("rsp_err", rsp_err, m_err);
                if (rsp_valid) begin
                    rq_cyc.push_back(cyc);
                    rq_dat.push_back(rsp_rdata);
                    rq_err.push_back(rsp_err);
                end
                if (cmd_valid && !busy) begin
                    have     = 1;
                    t_start  = cyc + 1;
                    m_paddr  = cmd_addr;
                    m_pwrite = cmd_write;
                    m_pwdata = cmd_wdata;
                    abort    = 0;
`ifdef APB_MASTER_TIMEOUT_EN
                    if (cmd_waits >= TMO) abort = 1;
`endif
                    if (abort) begin
                        t_done  = t_start + TMO + 1;
                        t_rdata = 0;
                        t_err   = 1;
                    end else begin
                        // 1 SETUP cycle, cmd_waits stalled ACCESS cycles, 1 ready cycle.
                        t_done  = t_start + cmd_waits + 2;
                        t_err   = cmd_err;
                        t_rdata = cmd_write ? 32'h0 : ref_mem[cmd_addr];
                        if (cmd_write && !cmd_err) ref_mem[cmd_addr] = cmd_wdata;
                    end
                    swq.push_back(cmd_waits);
                    seq.push_back(cmd_err);
                end
            end
        end
    end

    // Slave: registered pready, garbage on pready/pslverr/prdata whenever they must be ignored.
    initial begin
        pready = 0; pslverr = 0; prdata = 0; wl = 0; er = 0;
        foreach (slv_mem[i]) slv_mem[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                pready = 0; pslverr = 0; prdata = 0; wl = 0;
                swq.delete();
                seq.delete();
                foreach (slv_mem[i]) slv_mem[i] = 0;
            end else if (psel && !penable) begin
                if (swq.size() > 0) begin
                    wl = swq.pop_front();
                    er = seq.pop_front();
                end
                pready  = ($urandom % 2) == 1;
                pslverr = ($urandom % 2) == 1;
                prdata  = $urandom;
            end else if (psel && penable) begin
                if (wl > 0) begin
                    wl--;
                    pready  = 0;
                    pslverr = ($urandom % 2) == 1;
                    prdata  = $urandom;
                end else begin
                    pready  = 1;
                    pslverr = er;
                    prdata  = pwrite ? $urandom : slv_mem[paddr];
                    if (pwrite && !er) slv_mem[paddr] = pwdata;
                end
            end else begin
                pready  = ($urandom % 2) == 1;
                pslverr = ($urandom % 2) == 1;
                prdata  = $urandom;
            end
        end
    end

    task automatic send(input bit w, input logic [2:0] a, input logic [31:0] d,
                        input int ws, input bit e, output int acc);
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        cmd_waits = ws; cmd_err = e;
        acc = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (cmd_ready) begin
                acc = cyc;
                break;
            end
        end
        chk("cmd_accepted", acc >= 0, 1);
        @(posedge clk);
        #1;
        cmd_valid = 0;
    endtask

    task automatic wait_rsp(output logic [31:0] d, output logic e, output int c);
        bit got;
        got = 0; d = 0; e = 0; c = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(posedge clk);
            #2;
            if (rq_cyc.size() > 0) begin
                c = rq_cyc.pop_front();
                d = rq_dat.pop_front();
                e = rq_err.pop_front();
                got = 1;
            end
        end
        chk("rsp_arrived", got, 1);
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, rc, gap;
        int accs[8];
        int rcs[8];
        logic [31:0] d;
        logic e;

        rst = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
        cmd_waits = 1; cmd_err = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        repeat (2) @(posedge clk);
        #1;

        // Write then read address 5.
        send(1, 3'd5, 32'hDEADBEEF, 1, 0, acc);
        wait_rsp(d, e, rc);
        chk("wr5_latency", rc - acc, 4);
        chk("wr5_err", e, 0);
        chk("wr5_rdata", d, 0);
        send(0, 3'd5, 32'h0, 1, 0, acc);
        wait_rsp(d, e, rc);
        chk("rd5_latency", rc - acc, 4);
        chk("rd5_rdata", d, 32'hDEADBEEF);
        chk("rd5_err", e, 0);

        // Back-to-back writes with cmd_valid held.
        for (int a = 0; a < 8; a++)
            send(1, 3'(a), 32'(a) * 32'h11111111, 1, 0, accs[a]);
        for (int i = 0; i < 8; i++) begin
            wait_rsp(d, e, rcs[i]);
            if (i == 0) chk("b2b_first_latency", rcs[0] - accs[0], 4);
            else        chk("b2b_spacing", rcs[i] - rcs[i-1], 4);
        end
        send(0, 3'd7, 32'h0, 1, 0, acc);
        wait_rsp(d, e, rc);
        chk("rd7_rdata", d, 32'h77777777);

        // Slave error on read of address 2.
        send(0, 3'd2, 32'h0, 1, 1, acc);
        wait_rsp(d, e, rc);
        chk("err_rsp_err", e, 1);
        chk("err_latency", rc - acc, 4);

        // Five stalled ACCESS cycles.
        send(0, 3'd3, 32'h0, 5, 0, acc);
        wait_rsp(d, e, rc);
        chk("wait_latency", rc - acc, 8);
        chk("wait_rdata", d, 32'h33333333);
        chk("wait_err", e, 0);

`ifdef APB_MASTER_TIMEOUT_EN
        send(0, 3'd1, 32'h0, 1000, 0, acc);
        wait_rsp(d, e, rc);
        chk("tmo_latency", rc - acc, TMO + 2);
        chk("tmo_err", e, 1);
        chk("tmo_rdata", d, 0);
        send(0, 3'd1, 32'h0, TMO - 1, 0, acc);
        wait_rsp(d, e, rc);
        chk("tmo_edge_latency", rc - acc, TMO + 2);
        chk("tmo_edge_err", e, 0);
        chk("tmo_edge_rdata", d, 32'h11111111);
`endif

        // Random traffic, checked cycle by cycle by the model.
        for (int n = 0; n < 80; n++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            send(($urandom % 2) == 1, 3'($urandom), $urandom,
                 $urandom_range(1, 6), ($urandom % 8) == 0, acc);
        end
        repeat (20) @(posedge clk);
        #2;
        rq_cyc.delete(); rq_dat.delete(); rq_err.delete();

        // Reset in the middle of a stalled ACCESS.
        send(0, 3'd4, 32'h0, 50, 0, acc);
        repeat (3) @(posedge clk);
        #1 rst = 0;
        #1;
        chk("midrst_psel", psel, 0);
        chk("midrst_penable", penable, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1;
        repeat (10) @(posedge clk);
        #2;
        chk("midrst_no_rsp", rq_cyc.size(), 0);
        send(0, 3'd5, 32'h0, 1, 0, acc);
        wait_rsp(d, e, rc);
        chk("post_rst_rd5", d, 0);
        chk("post_rst_latency", rc - acc, 4);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

- Upstream APB requester for the 8-word APB register-slave stage.
- Accepts single read/write commands on a valid/ready command port and drives APB3 SETUP/ACCESS phases to the slave.
- Waits for `pready`, then returns read data and error status on a one-cycle response strobe.
- An optional watchdog aborts transfers the slave never completes.

## Interface
- `ADDR_W`, 3: APB address width; matches the slave's 8-entry map.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 16: ACCESS cycles with `pready` low before abort (timeout build only); legal 2..255.
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted when both are high at a rising edge.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_W: target address.
- `cmd_wdata` in DATA_W: write data.
- `rsp_valid` out 1: one-cycle completion strobe; no backpressure.
- `rsp_rdata` out DATA_W: read data; 0 for writes and aborts.
- `rsp_err` out 1: `pslverr` or timeout; qualified by `rsp_valid`.
- `psel` out 1: APB select.
- `penable` out 1: APB enable.
- `pwrite` out 1: APB direction.
- `paddr` out ADDR_W: APB address.
- `pwdata` out DATA_W: APB write data.
- `pready` in 1: slave ready.
- `pslverr` in 1: slave error.
- `prdata` in DATA_W: slave read data.

## Operation
- **States.** FSM states are IDLE, SETUP and ACCESS. All outputs are registered except `cmd_ready`, which equals (state == IDLE).
- **IDLE.** On `cmd_valid`, go to SETUP. Register `pwrite`, `paddr` and `pwdata` from the `cmd_*` inputs, and set `psel` = 1, `penable` = 0.
- **SETUP → ACCESS.** Always one cycle: `penable` = 1, other APB outputs held.
- **ACCESS, `pready` sampled high.** Complete the transfer:
  - drop `psel` and `penable` and return to IDLE;
  - on the same edge set `rsp_valid` = 1 and `rsp_err` = `pslverr`;
  - `rsp_rdata` = `prdata` for reads, 0 for writes.
- **ACCESS, `pready` sampled low.** Stay in ACCESS; `paddr`, `pwrite` and `pwdata` are held stable for the whole transfer.
- **Response outputs.** `rsp_valid` is high for exactly one cycle. `rsp_rdata` and `rsp_err` hold their values until the next completion.
- **Idle APB bus.** `paddr`, `pwrite` and `pwdata` keep their last values while idle; only `psel` and `penable` return to 0.
- **Ignored inputs.** `pready` and `pslverr` are ignored outside ACCESS, including a stale `pready` from the previous transfer during SETUP.
- **Reset values.** `rst` low forces immediately:
  - state IDLE;
  - `psel`, `penable`, `pwrite`, `rsp_valid`, `rsp_err` = 0;
  - `paddr`, `pwdata`, `rsp_rdata` = 0.
- **Reset mid-transfer.** Any in-flight transfer is dropped with no response. `cmd_ready` is 1 while in reset.

## Timing
- **Command accept.** A command accepted at edge E gives SETUP in cycle E..E+1 and ACCESS from E+1.
- **Zero-wait slave.** The slave registers `pready` one cycle into ACCESS, so minimum ACCESS length is 2 cycles.
- **Latency.** Command accept to `rsp_valid` is 4 cycles for the attached slave.
- **Back-to-back.** A new command can be accepted in the cycle `rsp_valid` is high. Peak rate is one transfer per 4 cycles.
- **Simultaneity.** `cmd_valid` arriving while busy is not accepted (`cmd_ready` = 0); the requester holds it.

## Configuration
- **`APB_MASTER_TIMEOUT_EN` defined.**
  - An 8-bit wait counter clears on entry to ACCESS and increments each ACCESS cycle with `pready` low.
  - When it reaches `TIMEOUT` with `pready` still low, the master aborts: `psel` and `penable` go to 0, state returns to IDLE, `rsp_valid` = 1, `rsp_err` = 1, `rsp_rdata` = 0.
  - If `pready` is high in the same cycle the count reaches `TIMEOUT`, the transfer completes normally.
- **`APB_MASTER_TIMEOUT_EN` undefined.** The counter is absent and the master waits in ACCESS indefinitely.

## Test plan
- **Write then read:** write 0xDEADBEEF to addr 5, then read addr 5 → `rsp_rdata` = 0xDEADBEEF, `rsp_err` = 0, each response 4 cycles after accept.
- **Back-to-back:** hold `cmd_valid` for writes to addr 0..7 with data = addr × 0x11111111 → 8 responses spaced 4 cycles apart; readback of addr 7 = 0x77777777; `paddr` is stable throughout each SETUP/ACCESS pair.
- **Error:** force `pslverr` = 1 on the read of addr 2 → `rsp_valid` = 1, `rsp_err` = 1.
- **Wait states:** stall `pready` for 5 ACCESS cycles → no response until `pready` = 1, then a correct response; APB outputs are stable while stalled.
- **Timeout (`APB_MASTER_TIMEOUT_EN`, `TIMEOUT` = 4):** tie `pready` = 0 → abort after 4 ACCESS cycles with `rsp_err` = 1, `rsp_rdata` = 0; the next command proceeds normally.
- **Reset mid-ACCESS:** pulse `rst` low mid-ACCESS → `psel` = `penable` = 0 immediately, no `rsp_valid`; a read of addr 5 after reset returns 0.
